// File: rtl/count_monitor_pkg.sv
// Shared definitions for the count event monitor: event type bits,
// event entry layout and tracking FSM encoding.
package count_monitor_pkg;

    // Width of one queued event entry: {type[1:0], count[3:0]}
    localparam int EVT_W = 6;

    // Event type bits within the type field
    localparam logic [1:0] EVT_MATCH = 2'b01;
    localparam logic [1:0] EVT_WRAP  = 2'b10;

    // Tracking FSM: INIT until a first sample establishes prev
    typedef enum logic {
        ST_INIT  = 1'b0,
        ST_TRACK = 1'b1
    } track_state_t;

    typedef struct packed {
        logic [1:0] typ;
        logic [3:0] count;
    } evt_entry_t;

endpackage

// File: rtl/count_event_monitor_if.sv
// Sample-side and event-side signals of the count event monitor.
// The master side is the upstream/consumer environment, the slave side is the monitor.
interface count_event_monitor_if
    import count_monitor_pkg::*;
#(
    parameter int WRAP_CNT_W = 8
);
    logic [3:0]            count_in;
    logic                  sample_en;
    logic                  match_en;
    logic [3:0]            match_val;
    logic                  clear;
    logic                  evt_valid;
    logic                  evt_ready;
    logic [EVT_W-1:0]      evt_data;
    logic                  overflow;
    logic [WRAP_CNT_W-1:0] wrap_count;

    modport master (
        output count_in, sample_en, match_en, match_val, clear, evt_ready,
        input  evt_valid, evt_data, overflow, wrap_count
    );

    modport slave (
        input  count_in, sample_en, match_en, match_val, clear, evt_ready,
        output evt_valid, evt_data, overflow, wrap_count
    );
endinterface

// File: rtl/sync_fifo.sv
// Synchronous first-word-fall-through FIFO. A push into a full FIFO is
// accepted when a pop happens in the same cycle. Head reads as zero when empty.
module sync_fifo #(
    parameter int WIDTH = 6,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign full     = (count == (AW+1)'(DEPTH));
    assign empty    = (count == '0);
    assign pop_data = empty ? '0 : mem[rd_ptr];

    // Pointer and occupancy bookkeeping; reset empties the FIFO
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage array; contents are only meaningful between the pointers
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/count_event_monitor.sv
// Watches an upstream 4-bit step counter, detects wraps (value went down)
// and matches against a compare value, and queues events for a consumer.
module count_event_monitor
    import count_monitor_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int WRAP_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    count_event_monitor_if.slave bus
);
    track_state_t          state_q;
    track_state_t          state_d;
    logic                  prev_valid;
    logic [3:0]            prev_p0;
    logic                  is_wrap;
    logic                  is_match;
    logic                  evt_push;
    evt_entry_t            evt_entry;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  fifo_pop;
    logic                  evt_drop;
    logic [EVT_W-1:0]      head_data;
    logic                  overflow_q;
    logic [WRAP_CNT_W-1:0] wrap_cnt_q;

    function automatic logic [WRAP_CNT_W-1:0] sat_inc(input logic [WRAP_CNT_W-1:0] v);
        return (&v) ? v : v + WRAP_CNT_W'(1);
    endfunction

    // Tracking state register
    always_ff @(posedge clk) begin
        if (!reset) state_q <= ST_INIT;
        else        state_q <= state_d;
    end

    // First valid sample leaves INIT; TRACK is terminal until reset
    always_comb begin
        state_d = state_q;
        if (state_q == ST_INIT && bus.sample_en) state_d = ST_TRACK;
    end

    // prev is only trustworthy once a sample has been taken
    always_comb begin
        prev_valid = (state_q == ST_TRACK);
    end

    // Previous-sample register, loaded on every valid sample
    always_ff @(posedge clk) begin
        if (!reset)             prev_p0 <= '0;
        else if (bus.sample_en) prev_p0 <= bus.count_in;
    end

    // Event detection; a repeated sample equal to match_val matches only once
    always_comb begin
        is_wrap   = bus.sample_en && prev_valid && (bus.count_in < prev_p0);
        is_match  = bus.sample_en && bus.match_en && (bus.count_in == bus.match_val)
                    && (!prev_valid || (prev_p0 != bus.match_val));
        evt_push  = is_wrap || is_match;
        evt_entry.typ   = (is_wrap ? EVT_WRAP : 2'b00) | (is_match ? EVT_MATCH : 2'b00);
        evt_entry.count = bus.count_in;
        fifo_pop  = !fifo_empty && bus.evt_ready;
        evt_drop  = evt_push && fifo_full && !fifo_pop;
    end

    sync_fifo #(
        .WIDTH (EVT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (evt_push),
        .push_data (evt_entry),
        .pop       (fifo_pop),
        .pop_data  (head_data),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Sticky drop flag; clear takes priority over a same-cycle drop
    always_ff @(posedge clk) begin
        if (!reset)         overflow_q <= 1'b0;
        else if (bus.clear) overflow_q <= 1'b0;
        else if (evt_drop)  overflow_q <= 1'b1;
    end

    // Saturating wrap counter; counts wraps even if the entry was dropped
    always_ff @(posedge clk) begin
        if (!reset)         wrap_cnt_q <= '0;
        else if (bus.clear) wrap_cnt_q <= '0;
        else if (is_wrap)   wrap_cnt_q <= sat_inc(wrap_cnt_q);
    end

    assign bus.evt_valid  = !fifo_empty;
    assign bus.evt_data   = head_data;
    assign bus.overflow   = overflow_q;
    assign bus.wrap_count = wrap_cnt_q;

endmodule

// File: doc/count_event_monitor.md
COUNT_EVENT_MONITOR -- requirements
Module: count_event_monitor

Interface
REQ-001 Parameter: FIFO_DEPTH, default 4, event FIFO entries (power of two, 2..16).
REQ-002 Parameter: WRAP_CNT_W, default 8, width of the wrap counter.
REQ-003 Port: clk  input  1  posedge clock, sole clock.
REQ-004 Port: reset  input  1  synchronous, active-low reset.
REQ-005 Port: count_in  input  4  current value of the upstream 4-bit step counter.
REQ-006 Port: sample_en  input  1  count_in valid this cycle; sampled on posedge.
REQ-007 Port: match_en  input  1  enables match detection.
REQ-008 Port: match_val  input  4  compare value for match detection.
REQ-009 Port: clear  input  1  synchronous clear of overflow flag and wrap counter.
REQ-010 Port: evt_valid  output  1  FIFO head holds an event.
REQ-011 Port: evt_ready  input  1  consumer accepts head this cycle.
REQ-012 Port: evt_data  output  6  head entry {type[1:0], count[3:0]}; type bit1=wrap, bit0=match.
REQ-013 Port: overflow  output  1  sticky: an event was dropped.
REQ-014 Port: wrap_count  output  WRAP_CNT_W  saturating count of wrap events.

Function
REQ-015 Tracking FSM states: INIT (no previous sample), TRACK (prev register valid); reset enters INIT; first sample_en moves INIT->TRACK; no other transitions.
REQ-016 Every sample_en cycle loads prev <= count_in.
REQ-017 Wrap event: sample_en, state TRACK, count_in < prev (unsigned); equal values are not a wrap.
REQ-018 Match event: sample_en, match_en, count_in == match_val, and (state INIT or prev != match_val); repeated equal samples give one match.
REQ-019 Wrap and match in the same sample produce one entry with type 2'b11; at most one push per cycle.
REQ-020 Pushed entry count field = count_in of the triggering sample.
REQ-021 Latency: event sampled at edge N drives evt_valid high from edge N (visible cycle N+1); first-word-fall-through.
REQ-022 Pop occurs when evt_valid && evt_ready; evt_data SHALL be stable while evt_valid && !evt_ready.
REQ-023 Full FIFO with event and pop in same cycle: pop then push, no drop.
REQ-024 Full FIFO with event and no pop: event dropped, overflow set, FIFO contents unchanged.
REQ-025 Empty FIFO with event and evt_ready high: entry is stored, not bypassed; evt_valid rises next cycle.
REQ-026 wrap_count increments per wrap event, saturates at all-ones, never wraps.
REQ-027 clear: overflow <= 0, wrap_count <= 0; clear wins over a same-cycle increment or drop; FIFO, prev and FSM unaffected; events still pushed.
REQ-028 sample_en low: no events, prev and FSM hold.

Reset
REQ-029 reset low at posedge: FSM INIT, prev 0, FIFO empty, evt_valid 0, evt_data 0, overflow 0, wrap_count 0.
REQ-030 Reset mid-operation discards all queued events; no event is generated in the reset cycle.
REQ-031 All state SHALL reset synchronously; no asynchronous reset term.

Structure
REQ-032 Shared package count_monitor_pkg holds event type constants (EVT_MATCH, EVT_WRAP), entry width 6 and FSM state encoding.
REQ-033 FIFO SHALL be a sub-module sync_fifo (parameterised width/depth, FWFT, full/empty, simultaneous push/pop when full).

Verification
REQ-034 Reset, samples 0,3,6,9,12,15,2 -> one entry {10,0010}, wrap_count 1, evt_valid one cycle after the 2 sample.
REQ-035 match_en=1, match_val=5, samples 4,5,5,5,6,5 -> two entries {01,0101}; no entry for repeats.
REQ-036 match_val=1, samples 14,1 -> single entry {11,0001}.
REQ-037 evt_ready=0, 5 wraps with FIFO_DEPTH=4 -> 4 entries held, overflow=1; clear -> overflow 0, wrap_count 0, 4 entries still drain in order.
REQ-038 FIFO full, wrap with evt_ready=1 same cycle -> no drop, overflow stays 0, occupancy stays 4.
REQ-039 Reset asserted with 3 queued entries -> evt_valid 0 next cycle; next sample 0 after 15 before reset produces no wrap.
